// File: rtl/simple_pipe_inst_feeder.sv
// Instruction feeder for the simplePipe datapath: buffers instructions in a small FIFO,
// issues one per cycle on `inst`, pulses `start` per issue, and counts issued ADDs.
module simple_pipe_inst_feeder #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [INST_W-1:0]          inst,
    output logic                       start,
    output logic                       is_add,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 add_cnt,
    output logic                       overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] OP_ADD = 2'b01;

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [7:0]        r_add_cnt;
    logic              r_overflow_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on registered occupancy, so a pop never frees a slot the same cycle.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign inst      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign start     = out_valid && out_ready;
    assign is_add    = out_valid && (inst[INST_W-1 -: 2] == OP_ADD);

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = start;

    assign count        = r_count;
    assign add_cnt      = r_add_cnt;
    assign overflow_err = r_overflow_err;

    // NOTE: storage is deliberately left out of reset; valid data is tracked by the pointers,
    // so resetting the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_add_cnt      <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (start && is_add && (r_add_cnt != 8'hFF)) begin
                r_add_cnt <= r_add_cnt + 8'd1;
            end
            if (in_valid && !in_ready) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simple_pipe_inst_feeder.sv
// Directed self-checking bench for simple_pipe_inst_feeder with hand-computed expectations.
module tb_simple_pipe_inst_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_inst;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] inst;
    logic       start;
    logic       is_add;
    logic [2:0] count;
    logic [7:0] add_cnt;
    logic       overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    simple_pipe_inst_feeder #(.DEPTH(4), .INST_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_inst      (in_inst),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .inst         (inst),
        .start        (start),
        .is_add       (is_add),
        .count        (count),
        .add_cnt      (add_cnt),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle just past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stalled(input logic [7:0] v);
        in_valid = 1'b1;
        in_inst  = v;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 8'h00; out_ready = 1'b1;

        // Reset and bubble
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check("rst_inst",      inst, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_start",     start, 1'b0);
        check("rst_is_add",    is_add, 1'b0);
        check("rst_in_ready",  in_ready, 1'b1);
        check("rst_add_cnt",   add_cnt, 8'd0);
        check("rst_count",     count, 3'd0);
        check("rst_ovf",       overflow_err, 1'b0);

        // Ordered issue, back-to-back
        in_valid = 1'b1; in_inst = 8'h42;
        #1 check("ord_no_bypass", start, 1'b0);
        cyc();
        check("ord_inst0", inst, 8'h42); check("ord_start0", start, 1'b1); check("ord_add0", is_add, 1'b1);
        in_inst = 8'h81;
        cyc();
        check("ord_inst1", inst, 8'h81); check("ord_start1", start, 1'b1); check("ord_add1", is_add, 1'b0);
        in_inst = 8'h5B;
        cyc();
        check("ord_inst2", inst, 8'h5B); check("ord_start2", start, 1'b1); check("ord_add2", is_add, 1'b1);
        in_valid = 1'b0;
        cyc();
        check("ord_empty",   out_valid, 1'b0);
        check("ord_start3",  start, 1'b0);
        check("ord_add_cnt", add_cnt, 8'd2);

        // Full and overflow
        out_ready = 1'b0;
        push_stalled(8'h11); push_stalled(8'h62); push_stalled(8'hC3); push_stalled(8'h74);
        check("full_count",    count, 3'd4);
        check("full_in_ready", in_ready, 1'b0);
        check("full_ovf0",     overflow_err, 1'b0);
        check("stall_start",   start, 1'b0);
        push_stalled(8'h55);
        check("ovf_set",       overflow_err, 1'b1);
        check("ovf_count",     count, 3'd4);
        check("stall_inst",    inst, 8'h11);
        out_ready = 1'b1;
        #1;
        check("drain_start0",  start, 1'b1);
        check("drain_inst0",   inst, 8'h11);
        check("full_pop_rdy",  in_ready, 1'b0);
        cyc(); check("drain_inst1", inst, 8'h62);
        cyc(); check("drain_inst2", inst, 8'hC3);
        cyc(); check("drain_inst3", inst, 8'h74);
        cyc(); check("drain_empty", out_valid, 1'b0);
        check("drain_add_cnt", add_cnt, 8'd4);
        check("ovf_sticky",    overflow_err, 1'b1);

        // Simultaneous push/pop at count=2
        out_ready = 1'b0;
        push_stalled(8'h01); push_stalled(8'h02);
        check("pp_count_pre", count, 3'd2);
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 8'h03;
        #1 check("pp_head", inst, 8'h01);
        cyc();
        in_valid = 1'b0;
        check("pp_count", count, 3'd2);
        check("pp_inst1", inst, 8'h02);
        cyc(); check("pp_inst2", inst, 8'h03); check("pp_count1", count, 3'd1);
        cyc(); check("pp_empty", out_valid, 1'b0);

        // Flush mid-stream with a same-cycle push
        out_ready = 1'b0;
        push_stalled(8'h44); push_stalled(8'h45); push_stalled(8'h46);
        check("fl_count_pre", count, 3'd3);
        flush = 1'b1; in_valid = 1'b1; in_inst = 8'h47;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count",     count, 3'd0);
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_inst",      inst, 8'h00);
        out_ready = 1'b1;
        cyc();
        check("fl_dropped",   out_valid, 1'b0);
        check("fl_add_cnt",   add_cnt, 8'd4);
        check("fl_ovf",       overflow_err, 1'b1);
        out_ready = 1'b0;
        push_stalled(8'h08);
        check("fl_after_inst",  inst, 8'h08);
        check("fl_after_count", count, 3'd1);
        out_ready = 1'b1;
        cyc();
        check("fl_after_empty", out_valid, 1'b0);

        // Saturation: reset, then issue 260 ADDs
        rst = 1'b1; cyc(); rst = 1'b0;
        in_valid = 1'b1; in_inst = 8'h40;
        for (int i = 1; i <= 260; i++) begin
            cyc();
            if (i == 255) check("sat_254", add_cnt, 8'd254);
        end
        check("sat_count", count, 3'd1);
        in_valid = 1'b0;
        cyc();
        check("sat_255",  add_cnt, 8'd255);
        cyc();
        check("sat_hold", add_cnt, 8'd255);

        // Mid-stream reset loses buffered data and clears counters
        out_ready = 1'b0;
        push_stalled(8'h41); push_stalled(8'h42);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("mrst_add_cnt",   add_cnt, 8'd0);
        check("mrst_count",     count, 3'd0);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_in_ready",  in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
